hadamard_output_transform: RTL and testbench

HADAMARD_OUTPUT_TRANSFORM -- requirements
Module: hadamard_output_transform

---
 rtl/hadamard_output_transform.sv | 116 +++++++++++
 tb/tb_hadamard_output_transform.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/hadamard_output_transform.sv
// Winograd F(4x4,3x3) output transform: Y = A^T (U .* V) A on 32-bit wrapping data.
// Element-wise products are formed one row per cycle, then T = A^T M and Y = T A.
module hadamard_output_transform (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [0:5][0:5][31:0]    v_tile,
   input  logic [0:5][0:5][31:0]    u_tile,
   output logic [0:3][0:3][31:0]    tile_out,
   output logic                     busy,
   output logic                     transform_done
);

   typedef logic [0:5][31:0] vec6_t;
   typedef logic [0:3][31:0] vec4_t;
   typedef enum logic [2:0] {IDLE, MULT, CALC_T, CALC_Y, DONE} state_t;

   state_t                  state_q, state_d;
   logic [2:0]              cnt_q, cnt_d;
   logic                    done_q, done_d;
   logic [0:5][0:5][31:0]   u_q, u_d, v_q, v_d, m_q, m_d;
   logic [0:3][0:5][31:0]   t_q, t_d;
   logic [0:3][0:3][31:0]   y_q, y_d;
   vec6_t                   col;
   vec4_t                   tcol;

   // Applies A^T to a 6-vector; scaling by 2/4/8 is done with shifts.
   function automatic vec4_t at_mul(input vec6_t x);
      vec4_t r;
      r[0] = x[0] + x[1] + x[2] + x[3] + x[4];
      r[1] = x[1] - x[2] + (x[3] << 1) - (x[4] << 1);
      r[2] = x[1] + x[2] + (x[3] << 2) + (x[4] << 2);
      r[3] = x[1] - x[2] + (x[3] << 3) - (x[4] << 3) + x[5];
      return r;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      u_d     = u_q;
      v_d     = v_q;
      m_d     = m_q;
      t_d     = t_q;
      y_d     = y_q;
      col     = '0;
      tcol    = '0;
      case (state_q)
         IDLE: begin
            if (start) begin
               u_d     = u_tile;
               v_d     = v_tile;
               cnt_d   = '0;
               state_d = MULT;
            end
         end
         MULT: begin
            for (int unsigned r = 0; r < 6; r++) begin
               if (cnt_q == 3'(r)) begin
                  for (int unsigned c = 0; c < 6; c++) begin
                     m_d[r][c] = u_q[r][c] * v_q[r][c];
                  end
               end
            end
            cnt_d = cnt_q + 3'd1;
            if (cnt_q >= 3'd5) state_d = CALC_T;
         end
         CALC_T: begin
            // T = A^T M, evaluated one column of M at a time.
            for (int unsigned j = 0; j < 6; j++) begin
               for (int unsigned k = 0; k < 6; k++) col[k] = m_q[k][j];
               tcol = at_mul(col);
               for (int unsigned i = 0; i < 4; i++) t_d[i][j] = tcol[i];
            end
            state_d = CALC_Y;
         end
         CALC_Y: begin
            // Row i of T A equals A^T applied to row i of T.
            for (int unsigned i = 0; i < 4; i++) y_d[i] = at_mul(t_q[i]);
            state_d = DONE;
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
         u_q     <= '0;
         v_q     <= '0;
         m_q     <= '0;
         t_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         u_q     <= u_d;
         v_q     <= v_d;
         m_q     <= m_d;
         t_q     <= t_d;
         y_q     <= y_d;
      end
   end

   assign tile_out       = y_q;
   assign busy           = (state_q != IDLE);
   assign transform_done = done_q;

endmodule

// File: tb/tb_hadamard_output_transform.sv
// Scoreboard bench for hadamard_output_transform: expected tiles are queued at start
// and compared against tile_out on each transform_done pulse.
module tb_hadamard_output_transform;

   typedef logic [0:5][0:5][31:0] tile6_t;
   typedef logic [0:3][0:3][31:0] tile4_t;

   logic    clk   = 1'b0;
   logic    rst_n = 1'b0;
   logic    start = 1'b0;
   tile6_t  v_tile = '0;
   tile6_t  u_tile = '0;
   tile4_t  tile_out;
   logic    busy;
   logic    transform_done;

   int      n_checks = 0;
   int      n_errors = 0;
   int      n_done = 0;
   int      n_expected_done = 0;
   tile4_t  sb[$];
   tile4_t  last_exp = '0;
   tile4_t  mon_exp;

   always #5 clk = ~clk;

   hadamard_output_transform dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .v_tile         (v_tile),
      .u_tile         (u_tile),
      .tile_out       (tile_out),
      .busy           (busy),
      .transform_done (transform_done)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic check_tile(input string tag, input tile4_t got, input tile4_t exp);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            check($sformatf("%s[%0d][%0d]", tag, i, j), got[i][j], exp[i][j]);
   endtask

   // Reference model: plain integer matrix products with A^T written out explicitly.
   function automatic tile4_t model(input tile6_t u, input tile6_t v);
      int at [4][6] = '{'{1, 1, 1, 1, 1, 0}, '{0, 1, -1, 2, -2, 0},
                        '{0, 1, 1, 4, 4, 0},  '{0, 1, -1, 8, -8, 1}};
      int m [6][6];
      int t [4][6];
      int acc;
      tile4_t y;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            m[i][j] = int'(u[i][j]) * int'(v[i][j]);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 6; j++) begin
            acc = 0;
            for (int k = 0; k < 6; k++) acc += at[i][k] * m[k][j];
            t[i][j] = acc;
         end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            acc = 0;
            for (int k = 0; k < 6; k++) acc += t[i][k] * at[j][k];
            y[i][j] = acc;
         end
      return y;
   endfunction

   function automatic tile6_t rand_tile();
      tile6_t r;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++)
            r[i][j] = $urandom;
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && transform_done) begin
         n_done++;
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            mon_exp = sb.pop_front();
            check_tile("y", tile_out, mon_exp);
         end
      end
   end

   // Called at a negedge; returns at the negedge right after the done edge.
   task automatic do_tile(input tile6_t u, input tile6_t v, input bit disturb);
      tile4_t e;
      int k;
      e = model(u, v);
      u_tile = u;
      v_tile = v;
      start  = 1'b1;
      sb.push_back(e);
      n_expected_done++;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      check("done_low_after_start", 32'(transform_done), 32'd0);
      check("busy_after_start", 32'(busy), 32'd1);
      if (disturb) begin
         v_tile = rand_tile();
         start  = 1'b1;
      end
      while (!transform_done && k < 20) begin
         @(negedge clk);
         k++;
         if (k == 3) start = 1'b0;
         if (k == 7) check_tile("hold", tile_out, last_exp);
      end
      check("done_latency", 32'(k), 32'd9);
      check("busy_at_done", 32'(busy), 32'd0);
      last_exp = e;
   endtask

   initial begin
      tile6_t u, v;
      int done_before;

      repeat (2) @(negedge clk);
      check_tile("reset_y", tile_out, '0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(transform_done), 32'd0);
      rst_n = 1'b1;

      // all ones
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) begin
            u[i][j] = 32'd1;
            v[i][j] = 32'd1;
         end
      do_tile(u, v, 1'b0);

      // single DC term, issued back-to-back
      v = '0;
      v[0][0] = 32'd7;
      do_tile(u, v, 1'b0);

      // corner element with negative product
      u = '0;
      v = '0;
      u[5][5] = -32'sd2;
      v[5][5] = 32'd3;
      do_tile(u, v, 1'b0);

      // product wraps to zero
      u = '0;
      v = '0;
      u[0][0] = 32'h0001_0000;
      v[0][0] = 32'h0001_0000;
      do_tile(u, v, 1'b0);

      // start re-asserted and v_tile changed mid-operation
      do_tile(rand_tile(), rand_tile(), 1'b1);
      do_tile(rand_tile(), rand_tile(), 1'b0);

      // reset during MULT aborts the tile
      @(negedge clk);
      u_tile = rand_tile();
      v_tile = rand_tile();
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      done_before = n_done;
      rst_n = 1'b0;
      #1;
      check_tile("abort_y", tile_out, '0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(transform_done), 32'd0);
      last_exp = '0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_no_done", 32'(n_done), 32'(done_before));
      check("abort_busy_idle", 32'(busy), 32'd0);
      do_tile(rand_tile(), rand_tile(), 1'b0);

      repeat (5) @(negedge clk);
      check("done_count", 32'(n_done), 32'(n_expected_done));
      check("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
